// File: rtl/seg_pkg.sv
// Shared types, glyph table and width helper for the 7-segment scan engine.
package seg_pkg;

  typedef logic [6:0] seg7_t;  // {g,f,e,d,c,b,a}, logical 1 = lit

  localparam seg7_t SEG_OFF = 7'h00;

  localparam seg7_t HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } scan_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/module_hex7seg.sv
// Combinational hex nibble to logical segment pattern.
module module_hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/module_seg_scan_mux.sv
// N-digit multiplexed 7-segment scan engine with dead time, blanking and pad polarity.
//   state   | meaning
//   ST_OFF  | en low or not yet started: all anodes inactive
//   ST_DEAD | dead counter running after a digit switch: anodes inactive
//   ST_ON   | anode of idx lit (unless blanked), segments show the shadow nibble
module module_seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned SCAN_HZ     = 1_000,
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DEAD_CYC    = 64,
  parameter bit          AN_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  output logic [N_DIGITS-1:0]   an_o,
  output seg7_t                 seg_o,
  output logic                  dp_o,
  output logic                  tick_o
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = width_of(DIV);
  localparam int unsigned IW  = width_of(N_DIGITS);
  localparam int unsigned DW  = width_of(DEAD_CYC + 1);

  localparam logic [PW-1:0]       PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [DW-1:0]       DEAD_LOAD  = DW'(DEAD_CYC);
  localparam logic [DW-1:0]       DEAD_ONE   = DW'(1);
  localparam logic [N_DIGITS-1:0] AN_PAD_OFF = {N_DIGITS{AN_ACT_LOW}};
  localparam seg7_t               SEG_PAD_OFF = SEG_OFF ^ {7{SEG_ACT_LOW}};

  if (DIV < 2) begin : g_chk_div
    $error("module_seg_scan_mux: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_chk_ndig
    $error("module_seg_scan_mux: N_DIGITS must be 2..8");
  end
  if (DEAD_CYC >= DIV) begin : g_chk_dead
    $error("module_seg_scan_mux: DEAD_CYC must be below the scan divider");
  end

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_nxt;
  logic                started_q;
  logic                tick_q;
  logic [3:0]          nib_q;
  logic                sdp_q, sblank_q;
  logic [DW-1:0]       dead_q, dead_d;
  scan_state_t         state_q, state_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  seg7_t               seg_q, seg_d;
  logic                dpo_q, dpo_d;
  logic                wrap;
  seg7_t               glyph;

  // Scan tick: prescaler wraps; held (not cleared) while en is low.
  assign wrap    = en && (presc_q == PRESC_LAST);
  assign presc_d = !en ? presc_q : (wrap ? '0 : presc_q + 1'b1);
  // The very first slot after reset is digit 0, not digit 1.
  assign idx_nxt = (!started_q || idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      tick_q    <= 1'b0;
      nib_q     <= '0;
      sdp_q     <= 1'b0;
      sblank_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= wrap;
      if (wrap) begin
        idx_q     <= idx_nxt;
        started_q <= 1'b1;
        nib_q     <= digits_i[{idx_nxt, 2'b00} +: 4];
        sdp_q     <= dp_i[idx_nxt];
        sblank_q  <= blank_i[idx_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    if (!en) begin
      state_d = ST_OFF;
      dead_d  = '0;
    end else if (wrap || (state_q == ST_OFF && started_q)) begin
      // New slot, or resuming after en: always pass through dead time.
      dead_d  = DEAD_LOAD;
      state_d = (DEAD_CYC == 0) ? ST_ON : ST_DEAD;
    end else begin
      case (state_q)
        ST_DEAD: begin
          if (dead_q <= DEAD_ONE) begin
            dead_d  = '0;
            state_d = ST_ON;
          end else begin
            dead_d = dead_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  module_hex7seg u_hex7seg (
    .nibble_i (nib_q),
    .seg_o    (glyph)
  );

  always_comb begin
    an_d  = AN_PAD_OFF;
    seg_d = SEG_PAD_OFF;
    dpo_d = SEG_ACT_LOW;
    if (en && state_q == ST_ON && !sblank_q) begin
      an_d        = '0;
      an_d[idx_q] = 1'b1;
      an_d        = an_d ^ AN_PAD_OFF;
      seg_d       = glyph ^ {7{SEG_ACT_LOW}};
      dpo_d       = sdp_q ^ SEG_ACT_LOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_PAD_OFF;
      seg_q <= SEG_PAD_OFF;
      dpo_q <= SEG_ACT_LOW;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
    end
  end

  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = dpo_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_module_seg_scan_mux.sv
// Randomized bench for module_seg_scan_mux against a slot-level reference model.
module tb_module_seg_scan_mux;

  localparam int DIV  = 10;
  localparam int N    = 4;
  localparam int DEAD = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b1;
  logic [15:0]  digits_i = 16'h3210;
  logic [3:0]   dp_i = 4'h0;
  logic [3:0]   blank_i = 4'h0;
  logic [3:0]   an_o;
  logic [6:0]   seg_o;
  logic         dp_o;
  logic         tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  module_seg_scan_mux #(
    .CLK_HZ(1000), .SCAN_HZ(100), .N_DIGITS(N), .DEAD_CYC(DEAD),
    .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference model: prescaler count, current slot, remaining dark cycles.
  int         m_p = 0, m_slot = 0, m_dark = 0;
  bit         m_started = 0, m_active = 0;
  logic [3:0] m_nib = 0;
  bit         m_dp = 0, m_blank = 0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1, e_tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit vis, wrap;
    if (!rst_n) begin
      m_p = 0; m_slot = 0; m_dark = 0; m_started = 0; m_active = 0;
      m_nib = 0; m_dp = 0; m_blank = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    end else begin
      vis    = en && m_active && (m_dark == 0) && !m_blank;
      e_an   = vis ? ~(4'b0001 << m_slot) : 4'hF;
      e_seg  = vis ? ~glyph(m_nib) : 7'h7F;
      e_dp   = vis ? ~m_dp : 1'b1;
      wrap   = en && (m_p == DIV - 1);
      e_tick = wrap;
      if (!en) begin
        m_active = 0;
      end else begin
        m_p = wrap ? 0 : m_p + 1;
        if (wrap) begin
          m_slot    = m_started ? (m_slot + 1) % N : 0;
          m_started = 1;
          m_nib     = digits_i[m_slot*4 +: 4];
          m_dp      = dp_i[m_slot];
          m_blank   = blank_i[m_slot];
          m_active  = 1;
          m_dark    = DEAD;
        end else if (!m_active) begin
          if (m_started) begin
            m_active = 1;
            m_dark   = DEAD;
          end
        end else if (m_dark > 0) begin
          m_dark = m_dark - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("an_o",   32'(an_o),   32'(e_an));
    check("seg_o",  32'(seg_o),  32'(e_seg));
    check("dp_o",   32'(dp_o),   32'(e_dp));
    check("tick_o", 32'(tick_o), 32'(e_tick));
    check("one_anode", 32'($countones(~an_o) <= 1), 32'd1);
  end

  a_one_anode: assert property (@(posedge clk) $countones(~an_o) <= 1);

  task automatic wait_tick(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (tick_o) break;
      if (n >= 40) begin
        check("tick_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_an(input logic [3:0] v, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (an_o == v) break;
      if (n >= 40) begin
        check("an_timeout", 32'(an_o), 32'(v));
        break;
      end
    end
  endtask

  initial begin
    int n, ticks;
    logic [3:0] saved;

    // Reset state and first tick latency
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'd1);
    check("rst_tick", 32'(tick_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_lat", 32'(n), 32'd10);

    // Anode walk and digit glyph
    wait_an(4'b1110, n);
    check("first_lit", 32'(n), 32'd3);
    wait_an(4'b1101, n);
    check("slot1_period", 32'(n), 32'd10);
    wait_an(4'b1011, n);
    check("slot2_period", 32'(n), 32'd10);
    check("slot2_seg", 32'(seg_o), 32'h24);
    wait_an(4'b0111, n);
    check("slot3_period", 32'(n), 32'd10);
    wait_an(4'b1110, n);
    check("wrap_period", 32'(n), 32'd10);

    // Dead time: old digit on the tick cycle, then exactly two dark cycles
    wait_tick(n);
    check("tick_cycle_old", 32'(an_o), 32'b1110);
    @(negedge clk); check("dead1", 32'(an_o), 32'hF);
    @(negedge clk); check("dead2", 32'(an_o), 32'hF);
    @(negedge clk); check("after_dead", 32'(an_o), 32'b1101);

    // Blank on digit 2, decimal point on digit 0
    blank_i = 4'b0100;
    dp_i    = 4'b0001;
    wait_tick(n);
    repeat (3) @(negedge clk);
    check("blank_an", 32'(an_o), 32'hF);
    check("blank_dp", 32'(dp_o), 32'd1);
    wait_tick(n);
    wait_tick(n);
    repeat (3) @(negedge clk);
    check("dp0_an", 32'(an_o), 32'b1110);
    check("dp0_dp", 32'(dp_o), 32'd0);

    // Mid-slot data change waits for the next tick
    blank_i  = 4'h0;
    dp_i     = 4'h0;
    digits_i = 16'h0000;
    wait_tick(n);
    repeat (3) @(negedge clk);
    check("zero_seg", 32'(seg_o), 32'h40);
    digits_i = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("hold_seg", 32'(seg_o), 32'h40);
    wait_tick(n);
    repeat (3) @(negedge clk);
    check("f_seg", 32'(seg_o), 32'h0E);
    check("f_an", 32'(an_o), 32'b1011);

    // en low mid-slot: dark next cycle, index and count held
    wait_tick(n);
    repeat (4) @(negedge clk);
    saved = an_o;
    check("pre_en_an", 32'(saved), 32'b0111);
    en = 1'b0;
    @(negedge clk);
    check("en_off_dark", 32'(an_o), 32'hF);
    ticks = 0;
    repeat (24) begin
      @(negedge clk);
      if (tick_o) ticks++;
    end
    check("en_off_no_tick", 32'(ticks), 32'd0);
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("en_resume_idx", 32'(an_o), 32'(saved));

    // Reset pulse mid-slot
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_an", 32'(an_o), 32'hF);
    check("rst_mid_seg", 32'(seg_o), 32'h7F);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_an(4'b1110, n);
    check("rst_restart_d0", 32'(n), 32'd13);

    // Randomized traffic
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) digits_i = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp_i = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blank_i = 4'($urandom);
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    en = 1'b1;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
